// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The master drives the hazard and redirect requests. The slave (pipe_ctrl) returns the stall, flush and redirect controls.
interface pipe_ctrl_if;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        load_use_i;
  logic        div_start_i;
  logic        div_done_i;
  logic        mem_wait_i;
  logic        irq_i;
  logic [31:0] irq_vec_i;
  logic [3:0]  stall_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        irq_ack_o;

  modport master (
    output jump_req_i, jump_addr_i, load_use_i, div_start_i, div_done_i,
           mem_wait_i, irq_i, irq_vec_i,
    input  stall_o, flush_if_id_o, flush_id_ex_o, redirect_o, redirect_pc_o,
           irq_ack_o
  );

  modport slave (
    input  jump_req_i, jump_addr_i, load_use_i, div_start_i, div_done_i,
           mem_wait_i, irq_i, irq_vec_i,
    output stall_o, flush_if_id_o, flush_id_ex_o, redirect_o, redirect_pc_o,
           irq_ack_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage core.
// Outputs are combinational from the FSM state and the inputs. Only the state and the flush counter are registered.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_DIV_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [3:0] C_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit         C_MULTI      = (FLUSH_CYCLES > 1);

  logic [1:0]  r_state;
  logic [3:0]  r_flush_cnt;
  logic [1:0]  w_next_state;
  logic [3:0]  w_next_cnt;
  logic [3:0]  w_stall;
  logic        w_flush_if_id;
  logic        w_flush_id_ex;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_irq_ack;

  // Request arbitration, output decode and next-state logic
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_flush_cnt;
    w_stall       = 4'b0000;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'h0000_0000;
    w_irq_ack     = 1'b0;
    if (rst) begin
      w_next_state = S_RUN;
      w_next_cnt   = 4'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.mem_wait_i) begin
            w_stall = 4'b1111;
          end else if (bus.jump_req_i || bus.irq_i) begin
            // A jump outranks the interrupt; the level irq is retaken after the flush window.
            w_redirect    = 1'b1;
            w_redirect_pc = bus.jump_req_i ? bus.jump_addr_i : bus.irq_vec_i;
            w_irq_ack     = ~bus.jump_req_i;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            if (C_MULTI) begin
              w_next_state = S_FLUSH;
              w_next_cnt   = C_FLUSH_INIT;
            end else begin
              w_next_state = S_RUN;
            end
          end else if (bus.div_start_i) begin
            w_stall      = 4'b0111;
            w_next_state = S_DIV_WAIT;
          end else if (bus.load_use_i) begin
            w_stall       = 4'b0011;
            w_flush_id_ex = 1'b1;
          end else begin
            w_stall = 4'b0000;
          end
        end
        S_DIV_WAIT: begin
          if (bus.mem_wait_i) begin
            w_stall = 4'b1111;
          end else if (bus.div_done_i) begin
            w_stall = 4'b0000;
          end else begin
            w_stall = 4'b0111;
          end
          if (bus.div_done_i) begin
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_DIV_WAIT;
          end
        end
        S_FLUSH: begin
          w_flush_if_id = 1'b1;
          if (bus.mem_wait_i) begin
            w_stall = 4'b1111;
          end else if (r_flush_cnt <= 4'd1) begin
            w_next_cnt   = 4'd0;
            w_next_state = S_RUN;
          end else begin
            w_next_cnt = r_flush_cnt - 4'd1;
          end
        end
        default: begin
          w_next_state = S_RUN;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

  // State and flush counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_cnt;
    end
  end

  assign bus.stall_o       = w_stall;
  assign bus.flush_if_id_o = w_flush_if_id;
  assign bus.flush_id_ex_o = w_flush_id_ex;
  assign bus.redirect_o    = w_redirect;
  assign bus.redirect_pc_o = w_redirect_pc;
  assign bus.irq_ack_o     = w_irq_ack;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios, then random traffic, compared against a cycle model.
// Two instances run side by side, one with FLUSH_CYCLES = 2 and one with FLUSH_CYCLES = 3.
module tb_pipe_ctrl;
  localparam int FC_A = 2;
  localparam int FC_B = 3;

  logic clk = 1'b0;
  logic rst;
  logic jump_req, load_use, div_start, div_done, mem_wait, irq;
  logic [31:0] jump_addr, irq_vec;

  always #5 clk = ~clk;

  pipe_ctrl_if bus_a ();
  pipe_ctrl_if bus_b ();

  assign bus_a.jump_req_i  = jump_req;
  assign bus_a.jump_addr_i = jump_addr;
  assign bus_a.load_use_i  = load_use;
  assign bus_a.div_start_i = div_start;
  assign bus_a.div_done_i  = div_done;
  assign bus_a.mem_wait_i  = mem_wait;
  assign bus_a.irq_i       = irq;
  assign bus_a.irq_vec_i   = irq_vec;
  assign bus_b.jump_req_i  = jump_req;
  assign bus_b.jump_addr_i = jump_addr;
  assign bus_b.load_use_i  = load_use;
  assign bus_b.div_start_i = div_start;
  assign bus_b.div_done_i  = div_done;
  assign bus_b.mem_wait_i  = mem_wait;
  assign bus_b.irq_i       = irq;
  assign bus_b.irq_vec_i   = irq_vec;

  pipe_ctrl #(.FLUSH_CYCLES(FC_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipe_ctrl #(.FLUSH_CYCLES(FC_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state: flush-only cycles still owed, and whether a divide is in flight
  int flush_left [2];
  bit div_busy   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fc(input int i);
    return (i == 0) ? FC_A : FC_B;
  endfunction

  task automatic model_eval(input int i, output logic [3:0] st, output logic fi,
                            output logic fe, output logic rd, output logic [31:0] pc,
                            output logic ack);
    st = 4'b0000; fi = 1'b0; fe = 1'b0; rd = 1'b0; pc = 32'h0; ack = 1'b0;
    if (rst) return;
    if (flush_left[i] > 0) begin
      fi = 1'b1;
      if (mem_wait) st = 4'b1111;
    end else if (div_busy[i]) begin
      st = mem_wait ? 4'b1111 : (div_done ? 4'b0000 : 4'b0111);
    end else if (mem_wait) begin
      st = 4'b1111;
    end else if (jump_req || irq) begin
      rd  = 1'b1;
      pc  = jump_req ? jump_addr : irq_vec;
      ack = !jump_req;
      fi  = 1'b1;
      fe  = 1'b1;
    end else if (div_start) begin
      st = 4'b0111;
    end else if (load_use) begin
      st = 4'b0011;
      fe = 1'b1;
    end
  endtask

  task automatic model_update(input int i);
    if (rst) begin
      flush_left[i] = 0;
      div_busy[i]   = 1'b0;
    end else if (flush_left[i] > 0) begin
      if (!mem_wait) flush_left[i]--;
    end else if (div_busy[i]) begin
      if (div_done) div_busy[i] = 1'b0;
    end else if (mem_wait) begin
      flush_left[i] = flush_left[i];
    end else if (jump_req || irq) begin
      flush_left[i] = fc(i) - 1;
    end else if (div_start) begin
      div_busy[i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [3:0] es, os;
    logic efi, efe, erd, eack, ofi, ofe, ord, oack;
    logic [31:0] epc, opc;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, es, efi, efe, erd, epc, eack);
      os   = (i == 0) ? bus_a.stall_o       : bus_b.stall_o;
      ofi  = (i == 0) ? bus_a.flush_if_id_o : bus_b.flush_if_id_o;
      ofe  = (i == 0) ? bus_a.flush_id_ex_o : bus_b.flush_id_ex_o;
      ord  = (i == 0) ? bus_a.redirect_o    : bus_b.redirect_o;
      opc  = (i == 0) ? bus_a.redirect_pc_o : bus_b.redirect_pc_o;
      oack = (i == 0) ? bus_a.irq_ack_o     : bus_b.irq_ack_o;
      chk($sformatf("stall_fc%0d", fc(i)),       {28'd0, os},  {28'd0, es});
      chk($sformatf("flush_if_id_fc%0d", fc(i)), {31'd0, ofi}, {31'd0, efi});
      chk($sformatf("flush_id_ex_fc%0d", fc(i)), {31'd0, ofe}, {31'd0, efe});
      chk($sformatf("redirect_fc%0d", fc(i)),    {31'd0, ord}, {31'd0, erd});
      chk($sformatf("redirect_pc_fc%0d", fc(i)), opc,          epc);
      chk($sformatf("irq_ack_fc%0d", fc(i)),     {31'd0, oack}, {31'd0, eack});
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle
  task automatic cycle();
    #3;
    compare_all();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    jump_req = 1'b0; load_use = 1'b0; div_start = 1'b0; div_done = 1'b0;
    mem_wait = 1'b0; irq = 1'b0; jump_addr = 32'h0; irq_vec = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      flush_left[i] = 0;
      div_busy[i]   = 1'b0;
    end
    clear_in();
    rst = 1'b1;
    @(posedge clk); #1;
    jump_req = 1'b1; jump_addr = 32'hDEAD_BEEF;
    cycle();
    clear_in();
    cycle();
    rst = 1'b0;
    cycle(); cycle();

    // Single jump to 0x100
    jump_req = 1'b1; jump_addr = 32'h0000_0100;
    cycle();
    clear_in();
    repeat (4) cycle();

    // Load-use held for two cycles
    load_use = 1'b1;
    cycle(); cycle();
    load_use = 1'b0;
    cycle();

    // Divide with an interrupt raised mid-wait
    div_start = 1'b1;
    cycle();
    div_start = 1'b0;
    cycle();
    irq = 1'b1; irq_vec = 32'h8000_0040;
    cycle(); cycle(); cycle();
    div_done = 1'b1;
    cycle();
    div_done = 1'b0;
    cycle();
    irq = 1'b0;
    repeat (4) cycle();

    // Jump and irq held behind a memory wait
    mem_wait = 1'b1; jump_req = 1'b1; jump_addr = 32'h0000_0200;
    irq = 1'b1; irq_vec = 32'h0000_0080;
    repeat (3) cycle();
    mem_wait = 1'b0;
    cycle();
    jump_req = 1'b0;
    repeat (3) cycle();
    irq = 1'b0;
    repeat (4) cycle();

    // Memory wait during the flush window
    jump_req = 1'b1; jump_addr = 32'h0000_0300;
    cycle();
    jump_req = 1'b0; mem_wait = 1'b1;
    cycle(); cycle();
    mem_wait = 1'b0;
    repeat (4) cycle();

    // Reset in the middle of a flush
    jump_req = 1'b1; jump_addr = 32'h0000_0400;
    cycle();
    jump_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      mem_wait  = ($urandom_range(99) < 20);
      jump_req  = ($urandom_range(99) < 12);
      irq       = ($urandom_range(99) < 12);
      load_use  = ($urandom_range(99) < 25);
      div_start = ($urandom_range(99) < 10);
      div_done  = !div_start && ($urandom_range(99) < 18);
      jump_addr = $urandom;
      irq_vec   = $urandom;
      rst       = ($urandom_range(99) < 2);
      cycle();
    end
    clear_in();
    rst = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
